// File: rtl/core_dispatch_pkg.sv
// Shared types for the N-wide dispatch stage: decoded instruction record,
// execution-class encoding and a one-hot register mask helper.
package core_dispatch_pkg;

    localparam int DISP_REG_W    = 4;
    localparam int DISP_MAX_REGS = 1 << DISP_REG_W;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_MUL    = 2'd1,
        CLS_LDST   = 2'd2,
        CLS_BRANCH = 2'd3
    } disp_cls_e;

    typedef struct packed {
        logic [DISP_REG_W-1:0] ra;
        logic [DISP_REG_W-1:0] rb;
        logic [DISP_REG_W-1:0] rd;
        logic                  uses_ra;
        logic                  uses_rb;
        logic                  writes_rd;
        disp_cls_e             cls;
    } disp_insn_t;

    // One-hot vector with bit r set when en is high, all-zero otherwise.
    function automatic logic [DISP_MAX_REGS-1:0] reg_mask(
        input logic [DISP_REG_W-1:0] r,
        input logic                  en
    );
        logic [DISP_MAX_REGS-1:0] m;
        m    = '0;
        m[r] = en;
        return m;
    endfunction

endpackage

// File: rtl/core_dispatch_select.sv
// Combinational issue selection: walks the head candidates oldest-first and
// stops at the first one blocked by a scoreboard hazard, an intra-group
// RAW/WAW hazard or an exhausted unit budget.
module core_dispatch_select
    import core_dispatch_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int NREGS     = 16,
    parameter int ALU_UNITS = 2
) (
    input  logic       [WIDTH-1:0]             i_cand_valid,
    input  disp_insn_t [WIDTH-1:0]             i_cand,
    input  logic       [NREGS-1:0]             i_busy,
    output logic       [WIDTH-1:0]             o_issue,
    output logic       [NREGS-1:0]             o_set_mask,
    output logic       [$clog2(WIDTH+1)-1:0]   o_num_issued
);

    localparam int NW = $clog2(WIDTH + 1);

    logic [NREGS-1:0] w_need [WIDTH];
    logic [NREGS-1:0] w_wr   [WIDTH];

    // Per-candidate register footprint: every register it reads or writes.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        logic [DISP_MAX_REGS-1:0] w_full_wr;
        logic [DISP_MAX_REGS-1:0] w_full_need;
        assign w_full_wr   = reg_mask(i_cand[gi].rd, i_cand[gi].writes_rd);
        assign w_full_need = reg_mask(i_cand[gi].ra, i_cand[gi].uses_ra)
                           | reg_mask(i_cand[gi].rb, i_cand[gi].uses_rb)
                           | w_full_wr;
        assign w_need[gi]  = w_full_need[NREGS-1:0];
        assign w_wr[gi]    = w_full_wr[NREGS-1:0];
    end

    // In-order selection with running hazard mask and per-class budgets.
    always_comb begin
        logic             w_chain;
        logic             w_budget;
        logic             w_mul_used;
        logic             w_ldst_used;
        logic             w_br_used;
        int               w_alu_cnt;
        int               w_n_iss;
        logic [NREGS-1:0] w_acc;

        o_issue     = '0;
        w_chain     = 1'b1;
        w_budget    = 1'b0;
        w_mul_used  = 1'b0;
        w_ldst_used = 1'b0;
        w_br_used   = 1'b0;
        w_alu_cnt   = 0;
        w_n_iss     = 0;
        w_acc       = '0;

        for (int k = 0; k < WIDTH; k++) begin
            case (i_cand[k].cls)
                CLS_ALU:    w_budget = (w_alu_cnt < ALU_UNITS);
                CLS_MUL:    w_budget = !w_mul_used;
                CLS_LDST:   w_budget = !w_ldst_used;
                CLS_BRANCH: w_budget = !w_br_used;
                default:    w_budget = 1'b0;
            endcase

            if (w_chain && i_cand_valid[k] && w_budget &&
                ((w_need[k] & (i_busy | w_acc)) == '0)) begin
                o_issue[k] = 1'b1;
                w_acc      = w_acc | w_wr[k];
                w_n_iss    = w_n_iss + 1;
                case (i_cand[k].cls)
                    CLS_ALU:    w_alu_cnt   = w_alu_cnt + 1;
                    CLS_MUL:    w_mul_used  = 1'b1;
                    CLS_LDST:   w_ldst_used = 1'b1;
                    CLS_BRANCH: w_br_used   = 1'b1;
                    default:    w_alu_cnt   = w_alu_cnt;
                endcase
            end else begin
                w_chain = 1'b0;
            end
        end

        o_set_mask   = w_acc;
        o_num_issued = NW'(w_n_iss);
    end

endmodule

// File: rtl/core_dispatch_nway.sv
// N-wide in-order dispatch stage: instruction queue, busy-register
// scoreboard and registered issue lanes (lane 0 oldest).
// Optional macro CORE_DISPATCH_WB_FWD_EN: when defined, the hazard check
// sees same-cycle writeback clears so a consumer can issue alongside its
// producer's writeback; otherwise one bubble follows writeback.
module core_dispatch_nway
    import core_dispatch_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int QDEPTH    = 8,
    parameter int NREGS     = 16,
    parameter int ALU_UNITS = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic       [WIDTH-1:0] i_in_valid,
    input  disp_insn_t [WIDTH-1:0] i_in_insn,
    input  logic                   i_flush,
    input  logic       [NREGS-1:0] i_wb_clr,
    output logic                   o_stall,
    output logic       [WIDTH-1:0] o_iss_valid,
    output disp_insn_t [WIDTH-1:0] o_iss_insn,
    output logic       [NREGS-1:0] o_busy
);

    localparam int QW = $clog2(QDEPTH);
    localparam int CW = QW + 1;
    localparam int NW = $clog2(WIDTH + 1);

    disp_insn_t             r_q [QDEPTH];
    logic       [QW-1:0]    r_head;
    logic       [QW-1:0]    r_tail;
    logic       [CW-1:0]    r_count;
    logic       [NREGS-1:0] r_busy;
    logic       [WIDTH-1:0] r_iss_valid;
    disp_insn_t [WIDTH-1:0] r_iss_insn;

    logic                   w_accept;
    logic       [QW-1:0]    w_enq_off [WIDTH];
    logic       [CW-1:0]    w_enq_cnt;
    logic       [CW-1:0]    w_enq;
    logic       [CW-1:0]    w_deq;
    disp_insn_t [WIDTH-1:0] w_cand;
    logic       [WIDTH-1:0] w_cand_valid;
    logic       [NREGS-1:0] w_busy_chk;
    logic       [WIDTH-1:0] w_issue;
    logic       [NREGS-1:0] w_set_mask;
    logic       [NW-1:0]    w_num_iss;

    // Stall is conservative: it only looks at the pre-dispatch occupancy.
    assign o_stall  = (CW'(QDEPTH) - r_count) < CW'(WIDTH);
    assign w_accept = !o_stall && !i_flush;

    // Compaction offsets: each valid slot lands after the valid slots before it.
    always_comb begin
        int w_cnt;
        w_cnt = 0;
        for (int s = 0; s < WIDTH; s++) begin
            w_enq_off[s] = QW'(w_cnt);
            if (i_in_valid[s]) w_cnt = w_cnt + 1;
        end
        w_enq_cnt = CW'(w_cnt);
    end

    // Head candidates; a flush suppresses all issue this cycle.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cand
        assign w_cand[gi]       = r_q[r_head + QW'(gi)];
        assign w_cand_valid[gi] = !i_flush && (r_count > CW'(gi));
    end

`ifdef CORE_DISPATCH_WB_FWD_EN
    assign w_busy_chk = r_busy & ~i_wb_clr;
`else
    assign w_busy_chk = r_busy;
`endif

    core_dispatch_select #(
        .WIDTH     (WIDTH),
        .NREGS     (NREGS),
        .ALU_UNITS (ALU_UNITS)
    ) u_select (
        .i_cand_valid (w_cand_valid),
        .i_cand       (w_cand),
        .i_busy       (w_busy_chk),
        .o_issue      (w_issue),
        .o_set_mask   (w_set_mask),
        .o_num_issued (w_num_iss)
    );

    assign w_enq = w_accept ? w_enq_cnt : '0;
    assign w_deq = CW'(w_num_iss);

    // Pointers, occupancy, scoreboard and issue-valid lanes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_busy      <= '0;
            r_iss_valid <= '0;
        end else begin
            // Set wins over a same-cycle writeback clear.
            r_busy      <= (r_busy & ~i_wb_clr) | w_set_mask;
            r_iss_valid <= w_issue;
            if (i_flush) begin
                r_head  <= r_tail;
                r_count <= '0;
            end else begin
                r_head  <= r_head + QW'(w_num_iss);
                r_tail  <= r_tail + QW'(w_enq);
                r_count <= r_count + w_enq - w_deq;
            end
        end
    end

    // Queue storage writes and issued-instruction payload (no reset needed).
    always_ff @(posedge i_clk) begin
        for (int s = 0; s < WIDTH; s++) begin
            if (w_accept && i_in_valid[s]) begin
                r_q[r_tail + w_enq_off[s]] <= i_in_insn[s];
            end
        end
        r_iss_insn <= w_cand;
    end

    assign o_iss_valid = r_iss_valid;
    assign o_iss_insn  = r_iss_insn;
    assign o_busy      = r_busy;

endmodule
